// File: rtl/gain_shift_var_if.sv
// Sample stream bundle for gain_shift_var: sample + gain exponent in, scaled sample + clip flag out.
// Handshake: a beat moves on a rising clk edge when valid && ready are both high; valid never
// waits on ready, and the sender holds data/shift stable while valid is high and ready is low.
interface gain_shift_var_if #(
    parameter int WordLengthBits = 12,
    parameter int ShiftWidthBits = 5
);
    logic [WordLengthBits-1:0] in;
    logic                      in_valid;
    logic                      in_ready;
    logic [ShiftWidthBits-1:0] shift;
    logic [WordLengthBits-1:0] out;
    logic                      out_valid;
    logic                      out_ready;
    logic                      saturated;

    modport master (
        output in, in_valid, shift, out_ready,
        input  in_ready, out, out_valid, saturated
    );

    modport slave (
        input  in, in_valid, shift, out_ready,
        output in_ready, out, out_valid, saturated
    );
endinterface

// File: rtl/gain_shift_var.sv
// Streaming signed power-of-two gain: saturating left shift, round-half-up right shift,
// two-stage pipeline with valid/ready backpressure and a saturating clip counter.
module gain_shift_var #(
    parameter int WordLengthBits = 12,
    parameter int ShiftWidthBits = 5,
    parameter int CountBits      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gain_shift_var_if.slave      s,
    input  logic                 clear_count,
    output logic [CountBits-1:0] sat_count
);
    localparam int W        = WordLengthBits;
    localparam int SW       = ShiftWidthBits;
    localparam int PW       = 2 * W;
    localparam int MaxShift = W - 1;
    localparam logic signed [PW-1:0] MaxPos = PW'((2 ** (W - 1)) - 1);
    localparam logic signed [PW-1:0] MinNeg = ~MaxPos;

    logic                 en;
    logic                 cnt_inc;
    int                   shift_i;
    int                   shift_c;
    int                   sh2;
    logic signed [PW-1:0] prod;
    logic signed [W:0]    rsum;
    logic signed [W:0]    rshf;
    logic [W-1:0]         res;
    logic                 res_sat;

    logic                 s1_valid_q, s1_valid_d;
    logic [W-1:0]         s1_data_q, s1_data_d;
    logic [SW-1:0]        s1_shift_q, s1_shift_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_q, out_d;
    logic                 sat_q, sat_d;
    logic [CountBits-1:0] cnt_q, cnt_d;

    // Clamping only shrinks the magnitude, so the clamped exponent always fits back into SW bits.
    always_comb begin
        shift_i = int'($signed(s.shift));
        shift_c = shift_i;
        if (shift_i > MaxShift) begin
            shift_c = MaxShift;
        end else if (shift_i < -MaxShift) begin
            shift_c = -MaxShift;
        end
    end

    always_comb begin
        sh2     = int'($signed(s1_shift_q));
        prod    = '0;
        rsum    = '0;
        rshf    = '0;
        res     = s1_data_q;
        res_sat = 1'b0;
        if (sh2 >= 0) begin
            prod = $signed({{W{s1_data_q[W-1]}}, s1_data_q}) <<< sh2;
            if (prod > MaxPos) begin
                res     = {1'b0, {(W - 1){1'b1}}};
                res_sat = 1'b1;
            end else if (prod < MinNeg) begin
                res     = {1'b1, {(W - 1){1'b0}}};
                res_sat = 1'b1;
            end else begin
                res = prod[W-1:0];
            end
        end else begin
            // One guard bit keeps +2^(k-1) from wrapping at the positive full-scale input.
            rsum = $signed({s1_data_q[W-1], s1_data_q}) + $signed((W + 1)'(1) << (-sh2 - 1));
            rshf = rsum >>> (-sh2);
            res  = rshf[W-1:0];
        end
    end

    always_comb begin
        en          = !out_valid_q || s.out_ready;
        s.in_ready  = en && !rst;
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_shift_d  = s1_shift_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        sat_d       = sat_q;
        if (en) begin
            s1_valid_d  = s.in_valid;
            s1_data_d   = s.in;
            s1_shift_d  = SW'(shift_c);
            out_valid_d = s1_valid_q;
            out_d       = res;
            sat_d       = res_sat && s1_valid_q;
        end

        cnt_inc = out_valid_q && s.out_ready && sat_q;
        cnt_d   = cnt_q;
        if (clear_count) begin
            cnt_d = cnt_inc ? CountBits'(1) : '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_shift_q  <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_shift_q  <= s1_shift_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
        end
    end

    assign s.out       = out_q;
    assign s.out_valid = out_valid_q;
    assign s.saturated = sat_q;
    assign sat_count   = cnt_q;
endmodule

// File: tb/tb_gain_shift_var.sv
// Directed bench for gain_shift_var (12-bit words, 5-bit shift, 2-bit clip counter).
module tb_gain_shift_var;
    localparam int WL = 12;
    localparam int SW = 5;
    localparam int CB = 2;

    logic          clk;
    logic          rst;
    logic          clear_count;
    logic [CB-1:0] sat_count;
    int            n_checks;
    int            n_errors;

    gain_shift_var_if #(.WordLengthBits(WL), .ShiftWidthBits(SW)) bus ();

    gain_shift_var #(
        .WordLengthBits(WL),
        .ShiftWidthBits(SW),
        .CountBits     (CB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus),
        .clear_count(clear_count),
        .sat_count  (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int out_s();
        return int'($signed(bus.out));
    endfunction

    // One isolated sample: accept, observe the empty output stage, then the result two edges later.
    task automatic send(input string tag, input int din, input int sh, input int exp_out,
                        input int exp_sat);
        bus.in       = WL'(din);
        bus.shift    = SW'(sh);
        bus.in_valid = 1'b1;
        #1 check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_lat1_valid"}, int'(bus.out_valid), 0);
        tick();
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_out"}, out_s(), exp_out);
        check({tag, "_sat"}, int'(bus.saturated), exp_sat);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        clear_count  = 1'b0;
        bus.in       = 12'hAAA;
        bus.in_valid = 1'b1;
        bus.shift    = '0;
        bus.out_ready = 1'b0;

        // Reset held with a valid input pending
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_out", out_s(), 0);
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_in_ready", int'(bus.in_ready), 0);
            check("rst_sat_count", int'(sat_count), 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1 check("post_rst_in_ready", int'(bus.in_ready), 1);

        // Left shift by 2
        bus.out_ready = 1'b1;
        send("l2_15", 15, 2, 60, 0);
        send("l2_511", 511, 2, 2044, 0);
        send("l2_m12", -12, 2, -48, 0);
        send("l2_m511", -511, 2, -2044, 0);
        send("l2_512", 512, 2, 2047, 1);
        send("l2_m513", -513, 2, -2048, 1);
        tick();
        check("l2_idle_valid", int'(bus.out_valid), 0);
        check("l2_sat_count", int'(sat_count), 2);

        // Right shift by 2 with round-half-up, then passthrough
        send("r2_6", 6, -2, 2, 0);
        send("r2_5", 5, -2, 1, 0);
        send("r2_m6", -6, -2, -1, 0);
        send("r2_m7", -7, -2, -2, 0);
        send("r2_2047", 2047, -2, 512, 0);
        send("r2_m2048", -2048, -2, -512, 0);
        send("s0_m1", -1, 0, -1, 0);

        // Exponent clamping
        send("clamp_p15", 1, 15, 2047, 1);
        send("clamp_m16_pos", 2047, -16, 1, 0);
        send("clamp_m16_neg", -2048, -16, -1, 0);
        tick();
        check("clamp_sat_count", int'(sat_count), 3);

        // Back-to-back stream at one sample per cycle
        bus.shift    = SW'(1);
        bus.in       = WL'(1);
        bus.in_valid = 1'b1;
        tick();
        check("tp_lat1_valid", int'(bus.out_valid), 0);
        bus.in = WL'(2);
        tick();
        check("tp_out0", out_s(), 2);
        bus.in = WL'(3);
        tick();
        check("tp_out1", out_s(), 4);
        bus.in_valid = 1'b0;
        tick();
        check("tp_out2", out_s(), 6);
        check("tp_out2_valid", int'(bus.out_valid), 1);
        tick();
        check("tp_drain_valid", int'(bus.out_valid), 0);

        // Backpressure: A and B taken, C stalls until out_ready rises
        bus.out_ready = 1'b0;
        bus.shift     = '0;
        bus.in        = WL'(100);
        bus.in_valid  = 1'b1;
        #1 check("bp_rdy_a", int'(bus.in_ready), 1);
        tick();
        bus.in = WL'(200);
        #1 check("bp_rdy_b", int'(bus.in_ready), 1);
        tick();
        bus.in = WL'(300);
        #1 check("bp_rdy_c", int'(bus.in_ready), 0);
        check("bp_hold_valid", int'(bus.out_valid), 1);
        check("bp_hold_a", out_s(), 100);
        repeat (3) tick();
        check("bp_stall_rdy", int'(bus.in_ready), 0);
        check("bp_stall_a", out_s(), 100);
        bus.out_ready = 1'b1;
        #1 check("bp_release_rdy", int'(bus.in_ready), 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_out_b", out_s(), 200);
        tick();
        check("bp_out_c", out_s(), 300);
        check("bp_out_c_valid", int'(bus.out_valid), 1);
        tick();
        check("bp_drain_valid", int'(bus.out_valid), 0);

        // Counter holds at all-ones after 5 saturated transfers
        send("cnt_sat4", 1, 15, 2047, 1);
        send("cnt_sat5", 1, 15, 2047, 1);
        tick();
        check("cnt_hold_max", int'(sat_count), 3);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        check("cnt_clear", int'(sat_count), 0);
        send("cnt_coinc", 1, 15, 2047, 1);
        clear_count = 1'b1;
        tick();
        clear_count = 1'b0;
        check("cnt_clear_and_inc", int'(sat_count), 1);

        // Saturated sample held under backpressure is not counted yet
        bus.out_ready = 1'b0;
        bus.in        = WL'(1);
        bus.shift     = SW'(15);
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("cnt_held_sat", int'(bus.saturated), 1);
        check("cnt_held_count", int'(sat_count), 1);
        bus.out_ready = 1'b1;
        tick();
        check("cnt_after_xfer", int'(sat_count), 2);

        // Reset while samples are in flight
        bus.out_ready = 1'b0;
        bus.shift     = '0;
        bus.in        = WL'(77);
        bus.in_valid  = 1'b1;
        tick();
        tick();
        check("mid_pre_valid", int'(bus.out_valid), 1);
        rst = 1'b1;
        #1 check("mid_rst_rdy", int'(bus.in_ready), 0);
        tick();
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_out", out_s(), 0);
        check("mid_rst_count", int'(sat_count), 0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("mid_post_valid", int'(bus.out_valid), 0);
        send("mid_first", 5, 0, 5, 0);
        tick();
        check("mid_final_valid", int'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gain_shift_var.md
Name: gain_shift_var

Overview:
- Streaming signed gain stage; gain set at runtime as a power-of-two shift, per sample.
- Positive shift multiplies by 2^shift, with saturation. Negative shift divides by 2^|shift|, rounding half toward +infinity.
- Two-stage pipeline with full valid/ready backpressure, a per-sample saturation flag and a saturating event counter.
- Sits between fixed-point DSP blocks (filters, decimators, AGC) in the rx/tx sample path.

Parameters:
- WordLengthBits, 12, width of in and out (two's complement).
- ShiftWidthBits, 5, width of signed shift port.
- CountBits, 16, width of sat_count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in  in  WordLengthBits  signed input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- shift  in  ShiftWidthBits  signed gain exponent; sampled together with in.
- out  out  WordLengthBits  signed output sample.
- out_valid  out  1  out holds a valid sample.
- out_ready  in  1  downstream accepts out this cycle.
- saturated  out  1  current out was clipped; qualified by out_valid.
- sat_count  out  CountBits  number of saturated samples transferred.
- clear_count  in  1  synchronous clear of sat_count.

Behaviour:
- Reset:
  - out=0, out_valid=0, saturated=0, sat_count=0, stage-1 valid=0.
  - in_ready=0 while rst is high.
- Pipeline advance enable: en = !out_valid || out_ready. in_ready = en && !rst (combinational).
- Input transfer when in_valid && in_ready. Stage 1 captures sample and clamped shift; stage-1 valid <= in_valid on every en cycle.
- On en: out/out_valid/saturated <= stage-1 result. When en=0, all registers hold.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput 1 sample/cycle. Order preserved.
- Shift clamp: shift is clamped to [-(WordLengthBits-1), +(WordLengthBits-1)] before use.
- Left shift (s>=0):
  - Full-precision product = in * 2^s.
  - If > 2^(W-1)-1, out = max positive and saturated=1.
  - If < -2^(W-1), out = min negative and saturated=1.
  - Otherwise exact, saturated=0. s=0 is a passthrough.
- Right shift (s<0, k=-s):
  - out = (in + 2^(k-1)) >>> k, computed in W+1 bits.
  - Cannot overflow; saturated=0.
- sat_count:
  - Increments on each output transfer (out_valid && out_ready && saturated).
  - Holds at all-ones; no wrap.
- clear_count: clears sat_count. If clear and increment occur in the same cycle, the result is 1.
- Reset mid-stream: all in-flight samples are discarded, with no output transfer during or after reset. First accept is possible on the cycle after rst deasserts.
- Bubbles: in_valid=0 cycles create stage-1 bubbles, which propagate as out_valid=0 when en.

Test Plan:
- Reset: hold rst 20 cycles with in_valid=1, in=0xAAA, out_ready=0 -> out=0, out_valid=0, in_ready=0, sat_count=0 throughout.
- Left shift, shift=+2, out_ready=1:
  - Inputs 15, 511, -12, -511 -> out 60, 2044, -48, -2044, each 2 cycles after accept, saturated=0.
  - Inputs 512, -513 -> out 2047, -2048, saturated=1.
- Right shift rounding, shift=-2:
  - Inputs 6, 5, -6, -7, 2047, -2048 -> out 2, 1, -1, -2, 512, -512.
  - shift=0, in=-1 -> out -1.
- Clamp: shift=+15, in=1 -> out 2047, saturated=1. shift=-16, in=2047 -> out 1; in=-2048 -> out -1.
- Backpressure, out_ready=0, stream A,B,C:
  - Only A and B are accepted; in_ready=0 from the cycle out_valid rises; out holds A.
  - Raise out_ready -> A, B, C emerge in order, with no loss or duplication.
- Counter, CountBits=2:
  - 5 saturated transfers -> sat_count=3.
  - Pulse clear_count -> 0.
  - Clear coincident with a saturated transfer -> 1.
  - Saturated samples held under out_ready=0 are not counted until transferred.
